// File: rtl/lock_pkg.sv
// lock_pkg: types and constants shared by the code-lock blocks
// (control FSM, pass_register, LED driver).
//   DIGIT_W / PASS_DIGITS / PASS_W : digit width, digits per password, password width
//   DEFAULT_PASS                   : password held after reset (digit 0 in the MS nibble)
//   digit_t / pass_t               : one digit / one full password
//   strobe_e, strobe_decode()      : resolves the pipo_* strobes to the single one that acts
package lock_pkg;

   localparam int unsigned DIGIT_W     = 4;
   localparam int unsigned PASS_DIGITS = 4;
   localparam int unsigned PASS_W      = DIGIT_W * PASS_DIGITS;

   localparam logic [PASS_W-1:0] DEFAULT_PASS = 16'h1234;

   typedef logic [DIGIT_W-1:0] digit_t;
   typedef logic [PASS_W-1:0]  pass_t;

   typedef enum logic [1:0] {
      STB_NONE  = 2'd0,
      STB_SHIFT = 2'd1,
      STB_LOAD  = 2'd2,
      STB_CLEAR = 2'd3
   } strobe_e;

   // Priority: clear > load > shift; only the winner takes effect.
   function automatic strobe_e strobe_decode(input logic i_clr,
                                             input logic i_load,
                                             input logic i_shift);
      strobe_e v_cmd;
      v_cmd = STB_NONE;
      if (i_clr)
         v_cmd = STB_CLEAR;
      else if (i_load)
         v_cmd = STB_LOAD;
      else if (i_shift)
         v_cmd = STB_SHIFT;
      return v_cmd;
   endfunction

endpackage

// File: rtl/pass_shift_reg.sv
// pass_shift_reg: digit entry register with saturating digit count.
//   clk, rst   : clock, asynchronous active-high reset
//   i_digit    : digit to append on STB_SHIFT
//   i_cmd      : resolved strobe (STB_CLEAR and STB_LOAD both empty the entry)
//   o_entry    : entered digits, newest in the LS nibble
//   o_count    : digits entered, saturating at DIGITS
//   o_full     : o_count == DIGITS
module pass_shift_reg
   import lock_pkg::*;
#(
   parameter int unsigned DIGITS = PASS_DIGITS,
   parameter int unsigned DW     = DIGIT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DW-1:0]        i_digit,
   input  strobe_e              i_cmd,
   output logic [DIGITS*DW-1:0] o_entry,
   output logic [3:0]           o_count,
   output logic                 o_full
);

   localparam int unsigned W        = DIGITS * DW;
   localparam logic [3:0]  FULL_CNT = 4'(DIGITS);

   logic [W-1:0]    r_entry;
   logic [3:0]      r_count;
   logic [W+DW-1:0] w_cat;
   logic [W-1:0]    w_shifted;

   // Slicing the wide concatenation keeps the shift valid for DIGITS == 1;
   // the oldest digit falls off the top.
   assign w_cat     = {r_entry, i_digit};
   assign w_shifted = w_cat[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_entry <= '0;
         r_count <= '0;
      end else begin
         case (i_cmd)
            STB_CLEAR, STB_LOAD: begin
               r_entry <= '0;
               r_count <= '0;
            end
            STB_SHIFT: begin
               r_entry <= w_shifted;
               if (r_count != FULL_CNT)
                  r_count <= r_count + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_entry = r_entry;
   assign o_count = r_count;
   assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/pass_register.sv
// pass_register: password storage and compare stage behind the code-lock FSM.
//   clk, rst     : clock, asynchronous active-high reset
//   digit        : digit from the keypad, sampled on pipo_shift
//   pipo_shift   : append digit to the entry register
//   pipo_reset   : clear entry and count (stored password kept)
//   pipo_load    : copy entry into the stored password, then clear entry
//   pass_check   : registered entry == stored flag, one cycle behind the registers
//   entry_count  : digits entered, saturating at DIGITS
//   entry_full   : entry_count == DIGITS
// Build option: define PASS_FULL_GATE_EN to require a full entry for pass_check.
module pass_register
   import lock_pkg::*;
#(
   parameter int unsigned          DIGITS       = PASS_DIGITS,
   parameter int unsigned          DW           = DIGIT_W,
   parameter logic [DIGITS*DW-1:0] DEFAULT_PASS = lock_pkg::DEFAULT_PASS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] digit,
   input  logic          pipo_shift,
   input  logic          pipo_reset,
   input  logic          pipo_load,
   output logic          pass_check,
   output logic [3:0]    entry_count,
   output logic          entry_full
);

   localparam int unsigned W = DIGITS * DW;

   strobe_e      w_cmd;
   logic [W-1:0] w_entry;
   logic [3:0]   w_count;
   logic         w_full;
   logic         w_match;
   logic [W-1:0] r_stored;
   logic         r_pass;

   assign w_cmd = strobe_decode(pipo_reset, pipo_load, pipo_shift);

   pass_shift_reg #(
      .DIGITS (DIGITS),
      .DW     (DW)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .i_digit (digit),
      .i_cmd   (w_cmd),
      .o_entry (w_entry),
      .o_count (w_count),
      .o_full  (w_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stored <= DEFAULT_PASS;
      else if (w_cmd == STB_LOAD)
         r_stored <= w_entry;
   end

`ifdef PASS_FULL_GATE_EN
   assign w_match = w_full && (w_entry == r_stored);
`else
   assign w_match = (w_entry == r_stored);
`endif

   // Compares the registered state, so a strobe at edge N shows here at N+1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pass <= 1'b0;
      else
         r_pass <= w_match;
   end

   assign pass_check  = r_pass;
   assign entry_count = w_count;
   assign entry_full  = w_full;

endmodule

// File: tb/tb_pass_register.sv
module tb_pass_register;

   logic       clk;
   logic       rst;
   logic [3:0] digit;
   logic       pipo_shift;
   logic       pipo_reset;
   logic       pipo_load;
   logic       pass_check;
   logic [3:0] entry_count;
   logic       entry_full;

   int unsigned n_cmp;
   int unsigned n_err;

   pass_register #(
      .DIGITS       (4),
      .DW           (4),
      .DEFAULT_PASS (16'h1234)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digit       (digit),
      .pipo_shift  (pipo_shift),
      .pipo_reset  (pipo_reset),
      .pipo_load   (pipo_load),
      .pass_check  (pass_check),
      .entry_count (entry_count),
      .entry_full  (entry_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One strobe cycle; returns at the negedge after the active edge.
   task automatic strobe(input logic sh, input logic ld, input logic clr, input logic [3:0] d);
      @(negedge clk);
      pipo_shift = sh;
      pipo_load  = ld;
      pipo_reset = clr;
      digit      = d;
      @(negedge clk);
      pipo_shift = 1'b0;
      pipo_load  = 1'b0;
      pipo_reset = 1'b0;
      digit      = 4'h0;
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   // Shift then one idle cycle so pass_check has caught up.
   task automatic shift(input logic [3:0] d);
      strobe(1'b1, 1'b0, 1'b0, d);
      idle();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      digit = 4'h0;
      pipo_shift = 1'b0;
      pipo_reset = 1'b0;
      pipo_load  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check_eq("rst_pass",   32'(pass_check),  32'd0);
      check_eq("rst_count",  32'(entry_count), 32'd0);
      check_eq("rst_full",   32'(entry_full),  32'd0);
      check_eq("rst_stored", 32'(dut.r_stored), 32'h1234);
      check_eq("rst_entry",  32'(dut.w_entry),  32'h0);

      // Correct default password, with one-cycle pass_check latency
      shift(4'h1); shift(4'h2); shift(4'h3);
      check_eq("cnt3", 32'(entry_count), 32'd3);
      check_eq("full3", 32'(entry_full), 32'd0);
      strobe(1'b1, 1'b0, 1'b0, 4'h4);
      check_eq("latency_pass", 32'(pass_check), 32'd0);
      check_eq("entry_1234",   32'(dut.w_entry), 32'h1234);
      check_eq("full4",        32'(entry_full), 32'd1);
      idle();
      check_eq("match_default", 32'(pass_check), 32'd1);

      // Wrong password then clear
      strobe(1'b0, 1'b0, 1'b1, 4'h0); idle();
      shift(4'h1); shift(4'h2); shift(4'h3); shift(4'h5);
      check_eq("entry_1235", 32'(dut.w_entry), 32'h1235);
      check_eq("wrong_pass", 32'(pass_check), 32'd0);
      strobe(1'b0, 1'b0, 1'b1, 4'h0);
      check_eq("clr_entry", 32'(dut.w_entry), 32'h0);
      check_eq("clr_count", 32'(entry_count), 32'd0);
      check_eq("clr_full",  32'(entry_full),  32'd0);
      idle();
      check_eq("clr_pass",  32'(pass_check), 32'd0);

      // Five digits: oldest dropped, count saturates
      shift(4'h9); shift(4'h1); shift(4'h2); shift(4'h3);
      check_eq("five_entry4", 32'(dut.w_entry), 32'h9123);
      shift(4'h4);
      check_eq("five_entry", 32'(dut.w_entry), 32'h1234);
      check_eq("five_count", 32'(entry_count), 32'd4);
      check_eq("five_pass",  32'(pass_check), 32'd1);

      // All strobes at once: only the clear acts
      strobe(1'b1, 1'b1, 1'b1, 4'h7);
      check_eq("prio_stored", 32'(dut.r_stored), 32'h1234);
      check_eq("prio_entry",  32'(dut.w_entry),  32'h0);
      check_eq("prio_count",  32'(entry_count),  32'd0);
      idle();
      check_eq("prio_pass",   32'(pass_check),   32'd0);

      // Load a new password
      shift(4'hA); shift(4'hB); shift(4'hC); shift(4'hD);
      strobe(1'b0, 1'b1, 1'b0, 4'h0);
      check_eq("load_stored", 32'(dut.r_stored), 32'hABCD);
      check_eq("load_entry",  32'(dut.w_entry),  32'h0);
      check_eq("load_count",  32'(entry_count),  32'd0);
      idle();
      check_eq("load_pass",   32'(pass_check),   32'd0);
      shift(4'hA); shift(4'hB); shift(4'hC); shift(4'hD);
      check_eq("new_match", 32'(pass_check), 32'd1);
      strobe(1'b0, 1'b0, 1'b1, 4'h0); idle();
      shift(4'h1); shift(4'h2); shift(4'h3); shift(4'h4);
      check_eq("old_no_match", 32'(pass_check), 32'd0);

      // Asynchronous reset mid-entry
      strobe(1'b0, 1'b0, 1'b1, 4'h0); idle();
      shift(4'h5); shift(4'h6);
      check_eq("mid_count", 32'(entry_count), 32'd2);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_count",  32'(entry_count),  32'd0);
      check_eq("arst_full",   32'(entry_full),   32'd0);
      check_eq("arst_pass",   32'(pass_check),   32'd0);
      check_eq("arst_entry",  32'(dut.w_entry),  32'h0);
      check_eq("arst_stored", 32'(dut.r_stored), 32'h1234);
      @(negedge clk);
      rst = 1'b0;

      // Load an empty entry: stored becomes 0 and matches the empty entry
      strobe(1'b0, 1'b1, 1'b0, 4'h0);
      check_eq("zero_stored", 32'(dut.r_stored), 32'h0);
      idle();
`ifdef PASS_FULL_GATE_EN
      check_eq("zero_empty_pass", 32'(pass_check), 32'd0);
`else
      check_eq("zero_empty_pass", 32'(pass_check), 32'd1);
`endif
      shift(4'h1); shift(4'h2); shift(4'h3);
      check_eq("partial_pass", 32'(pass_check), 32'd0);
      strobe(1'b0, 1'b0, 1'b1, 4'h0); idle();
      shift(4'h0); shift(4'h0); shift(4'h0); shift(4'h0);
      check_eq("zero_full_pass", 32'(pass_check), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
